seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing controller that shares one registered hex-to-7-segment decoder across NUM_DIGITS common-anode/cathode digits. It presents one nibble at a time to the shared decoder and drives a one-hot digit enable. The enable is aligned to the decoder's 1-cycle latency and followed by an anti-ghosting blank gap. New display values arrive on a valid/ready load port and are double-buffered so that a frame never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
CLKS_PER_DIGIT, 25000, cycles each digit's enable is held high (1 ms at 25 MHz); must be >= 1.
BLANK_CLKS, 2500, cycles all enables are low after each digit (ghost guard); 0 means no BLANK state.

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Load_Valid  in  1  new display value offered
i_Load_Value  in  4*NUM_DIGITS  nibble k at bits [4k+3:4k]
o_Load_Ready  out  1  pending buffer empty; load accepted when valid&&ready at posedge
i_LZ_Suppress  in  1  enable leading-zero blanking (sampled every cycle)
o_Digit_Num  out  4  nibble to shared decoder input (registered)
o_Digit_En  out  NUM_DIGITS  one-hot digit enable, active-high (registered)
o_Frame_Start  out  1  1-cycle pulse on entry to SETUP of digit 0

Behaviour:
- Reset (async assert, sync release): state=SETUP, digit index=0, counter=0, active value=0, pending empty. Outputs: o_Digit_En=0, o_Digit_Num=0, o_Load_Ready=1, o_Frame_Start=0.
- Per-digit FSM: SETUP (1 cycle) -> ON (CLKS_PER_DIGIT cycles) -> BLANK (BLANK_CLKS cycles; skipped if 0) -> SETUP of next digit.
  - SETUP: o_Digit_Num <= active nibble[idx]; o_Digit_En=0. The decoder registers the nibble during this cycle.
  - ON: o_Digit_En[idx]=1 unless suppressed; o_Digit_Num held.
  - BLANK: o_Digit_En=0.
- Digit period = 1+CLKS_PER_DIGIT+BLANK_CLKS cycles. Frame = NUM_DIGITS periods.
- Index wrap: after digit NUM_DIGITS-1, the index wraps to 0.
- Frame swap: on the transition into SETUP of digit 0, if pending is valid, then active <= pending and pending is cleared. o_Frame_Start pulses in that SETUP cycle. Swaps occur only at frame boundaries; a mid-frame load never alters the digits currently being scanned.
- Load handshake:
  - o_Load_Ready = !pending_valid.
  - An accepted load writes pending and drops ready on the next cycle.
  - A load accepted in the same cycle as a swap check is not seen by that swap; it lands in pending and swaps at the next frame.
  - Ready rises the cycle after the swap.
  - While ready=0, valid is ignored; the value is held off by the source.
- Leading-zero suppression: digit k>0 is suppressed when i_LZ_Suppress=1 and active nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed, so value 0 shows a single "0". Suppressed digits keep full timing with enable low.
- Counter width: $clog2(max(CLKS_PER_DIGIT,BLANK_CLKS)+1). It reloads on each state entry, so there is no overflow.
- Reset mid-operation: all state is cleared immediately (async), any pending load is discarded, and enables drop in the same cycle as reset assertion.

Decomposition:
- Package seven_seg_pkg: scan-state enum (SETUP, ON, BLANK), NIBBLE_W=4 constant, and a function for the counter width.
- Sub-module seven_seg_lz_mask: combinational; input active value, outputs NUM_DIGITS suppress mask.
- The shared decoder is instantiated by the parent, not inside this block.

Test Plan (NUM_DIGITS=4, CLKS_PER_DIGIT=4, BLANK_CLKS=1):
1. Reset then idle, no load -> o_Frame_Start every 24 cycles. Each digit shows 1 SETUP cycle with En=0000, 4 cycles En=0001/0010/0100/1000 in sequence, then 1 blank cycle. o_Digit_Num=0 throughout.
2. Load 16'h1A3F mid-frame (cycle 7) -> ready drops at cycle 8. The current frame still shows 0s. At the next SETUP of digit 0, the Num sequence is F,3,A,1 and ready rises the following cycle.
3. Second load of 16'h2222 while pending is full -> ignored (ready=0). It is accepted only after the swap, then displayed one frame later.
4. i_LZ_Suppress=1, value 16'h0050 -> En pulses only for digits 0 and 1. Digits 2 and 3 keep timing with En=0000. Value 16'h0000 -> only digit 0 is enabled.
5. Valid asserted in the exact swap-check cycle with pending empty -> not swapped that frame; displayed at the following frame boundary.
6. Assert i_Reset during digit 2 ON -> En=0000 and Num=0 immediately; ready=1. After release, SETUP of digit 0 with o_Frame_Start=1.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: scan states,
// nibble width and the dwell-counter width helper.
package seven_seg_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_SETUP = 2'd0;
    localparam scan_state_t ST_ON    = 2'd1;
    localparam scan_state_t ST_BLANK = 2'd2;

    // Wide enough to hold the longer of the ON and BLANK dwell reloads.
    function automatic int unsigned cnt_width(input int unsigned on_clks,
                                              input int unsigned blank_clks);
        int unsigned longest;
        longest = (on_clks > blank_clks) ? on_clks : blank_clks;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero mask: bit k (k>0) is set when nibbles k..NUM_DIGITS-1 are all zero.
module seven_seg_lz_mask
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
    output logic [NUM_DIGITS-1:0]          mask_o
);

    logic upper_zero;

    // Walk from the most significant digit down; digit 0 is never masked.
    always_comb begin
        mask_o     = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (value_i[k*NIBBLE_W +: NIBBLE_W] == 4'd0);
            mask_o[k]  = upper_zero;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding a shared registered 7-seg decoder,
// with blank guard between digits and a frame-aligned double-buffered load port.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLKS_PER_DIGIT = 25000,
    parameter int unsigned BLANK_CLKS     = 2500
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Load_Valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Load_Value,
    output logic                           o_Load_Ready,
    input  logic                           i_LZ_Suppress,
    output logic [NIBBLE_W-1:0]            o_Digit_Num,
    output logic [NUM_DIGITS-1:0]          o_Digit_En,
    output logic                           o_Frame_Start
);

    localparam int unsigned VAL_W      = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W      = cnt_width(CLKS_PER_DIGIT, BLANK_CLKS);
    localparam int unsigned ON_LOAD    = CLKS_PER_DIGIT - 1;
    localparam int unsigned BLANK_LOAD = (BLANK_CLKS > 0) ? BLANK_CLKS - 1 : 0;
    localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic [VAL_W-1:0]      pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [NIBBLE_W-1:0]   num_q, num_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  fs_q, fs_d;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [VAL_W-1:0]      active_shifted;

    seven_seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .value_i (active_q),
        .mask_o  (lz_mask)
    );

    assign idx_next       = (idx_q == IDX_W'(LAST_IDX)) ? '0 : idx_q + IDX_W'(1);
    assign active_shifted = active_d >> (NIBBLE_W * 32'(idx_q));

    // state_q is the phase being presented next; outputs register its decode,
    // so the nibble reaches the decoder one cycle ahead of the enable.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        num_d        = num_q;
        en_d         = '0;
        fs_d         = 1'b0;

        // Swap uses the pre-edge pending; a same-edge load waits a frame.
        if (state_q == ST_SETUP && idx_q == '0 && pend_valid_q) begin
            active_d     = pending_q;
            pend_valid_d = 1'b0;
        end
        if (i_Load_Valid && !pend_valid_q) begin
            pending_d    = i_Load_Value;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            ST_SETUP: begin
                num_d   = active_shifted[NIBBLE_W-1:0];
                fs_d    = (idx_q == '0);
                state_d = ST_ON;
                cnt_d   = CNT_W'(ON_LOAD);
            end
            ST_ON: begin
                en_d = (NUM_DIGITS'(1) << idx_q) & ~(lz_mask & {NUM_DIGITS{i_LZ_Suppress}});
                if (cnt_q == '0) begin
                    if (BLANK_CLKS > 0) begin
                        state_d = ST_BLANK;
                        cnt_d   = CNT_W'(BLANK_LOAD);
                    end else begin
                        state_d = ST_SETUP;
                        idx_d   = idx_next;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETUP;
                    idx_d   = idx_next;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SETUP;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_SETUP;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            num_q        <= '0;
            en_q         <= '0;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            num_q        <= num_d;
            en_q         <= en_d;
            fs_q         <= fs_d;
        end
    end

    assign o_Load_Ready  = !pend_valid_q;
    assign o_Digit_Num   = num_q;
    assign o_Digit_En    = en_q;
    assign o_Frame_Start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a frame-arithmetic model
// (digit/phase derived from the cycle count since reset release).
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int CPD   = 4;
    localparam int BC    = 1;
    localparam int PER   = 1 + CPD + BC;
    localparam int FRAME = ND * PER;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] value;
    logic        lz;
    logic        ready;
    logic [3:0]  num;
    logic [3:0]  en;
    logic        fs;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .CLKS_PER_DIGIT (CPD),
        .BLANK_CLKS     (BC)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Load_Valid  (valid),
        .i_Load_Value  (value),
        .o_Load_Ready  (ready),
        .i_LZ_Suppress (lz),
        .o_Digit_Num   (num),
        .o_Digit_En    (en),
        .o_Frame_Start (fs)
    );

    int          checks   = 0;
    int          failures = 0;
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    bit          m_pend_v;
    logic [3:0]  m_num;
    bit          m_accepted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = '0;
        m_pend   = '0;
        m_pend_v = 1'b0;
        m_num    = '0;
        t        = 0;
    endtask

    // Advance one clock; output cycle t sits at frame position t mod FRAME.
    task automatic step();
        int         p, digit, ph;
        bit         acc;
        logic [3:0] exp_en;
        @(posedge clk);
        #1;
        p     = t % FRAME;
        digit = p / PER;
        ph    = p % PER;
        acc   = valid && !m_pend_v;
        if (p == 0 && m_pend_v) begin
            m_active = m_pend;
            m_pend_v = 1'b0;
        end
        if (acc) begin
            m_pend   = value;
            m_pend_v = 1'b1;
        end
        m_accepted = acc;
        if (ph == 0) m_num = 4'(m_active >> (4 * digit));
        exp_en = '0;
        if (ph >= 1 && ph <= CPD) begin
            if (digit == 0 || !lz || (m_active >> (4 * digit)) != 16'd0)
                exp_en = 4'(1 << digit);
        end
        check_eq("digit_en",    32'(en),    32'(exp_en));
        check_eq("digit_num",   32'(num),   32'(m_num));
        check_eq("frame_start", 32'(fs),    32'(p == 0));
        check_eq("load_ready",  32'(ready), 32'(!m_pend_v));
        t++;
    endtask

    // Source holds valid until the load is taken, within a cycle budget.
    task automatic offer(input logic [15:0] v, input int budget);
        bit done;
        done  = 1'b0;
        valid = 1'b1;
        value = v;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = m_accepted;
        end
        valid = 1'b0;
        check_eq("offer_accepted", 32'(done), 32'd1);
    endtask

    task automatic align_last(input int target_p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            step();
            hit = (((t - 1) % FRAME) == target_p);
        end
        check_eq("align_reached", 32'(hit), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        value = '0;
        lz    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_en",    32'(en),    32'd0);
        check_eq("reset_num",   32'(num),   32'd0);
        check_eq("reset_ready", 32'(ready), 32'd1);
        check_eq("reset_fs",    32'(fs),    32'd0);
        #1 rst = 1'b0;

        // Idle scanning of zeros.
        repeat (2 * FRAME) step();

        // Mid-frame load, then a second load held off while pending is full.
        repeat (7) step();
        offer(16'h1A3F, 2);
        offer(16'h2222, 3 * FRAME);
        repeat (2 * FRAME) step();

        // Leading-zero suppression.
        lz = 1'b1;
        offer(16'h0050, 3 * FRAME);
        repeat (2 * FRAME) step();
        offer(16'h0000, 3 * FRAME);
        repeat (2 * FRAME) step();
        offer(16'h0305, 3 * FRAME);
        repeat (2 * FRAME) step();
        lz = 1'b0;

        // Load offered exactly in the swap-check cycle with pending empty.
        align_last(FRAME - 1);
        check_eq("ready_before_swap_check", 32'(ready), 32'd1);
        offer(16'hBEEF, 1);
        repeat (2 * FRAME) step();

        // Async reset during digit 2 ON with a load pending.
        align_last(PER + 2);
        offer(16'h7777, 1);
        align_last(2 * PER + 2);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_en",    32'(en),    32'd0);
        check_eq("midrst_num",   32'(num),   32'd0);
        check_eq("midrst_ready", 32'(ready), 32'd1);
        check_eq("midrst_fs",    32'(fs),    32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        repeat (2 * FRAME) step();

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            valid = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       value = 16'($urandom_range(0, 15));
                1:       value = 16'($urandom_range(0, 255));
                2:       value = 16'($urandom_range(0, 4095));
                default: value = 16'($urandom);
            endcase
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            step();
        end
        valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
